// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue sequencer: FSM state encoding,
// ALU function codes and the 24-bit instruction word layout.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] FUNC_ADD  = 4'h0;
  localparam logic [3:0] FUNC_SUB  = 4'h1;
  localparam logic [3:0] FUNC_AND  = 4'h2;
  localparam logic [3:0] FUNC_OR   = 4'h3;
  localparam logic [3:0] FUNC_XOR  = 4'h4;
  localparam logic [3:0] FUNC_SLL  = 4'h5;
  localparam logic [3:0] FUNC_SRL  = 4'h6;
  localparam logic [3:0] FUNC_SRA  = 4'h7;
  localparam logic [3:0] FUNC_SLT  = 4'h8;
  localparam logic [3:0] FUNC_SLTU = 4'h9;
  localparam logic [3:0] FUNC_MUL  = 4'hA;
  localparam logic [3:0] FUNC_PASS = 4'hB;
  localparam logic [3:0] FUNC_HALT = 4'hF;

  localparam int INSTR_W  = 24;
  localparam int REG_W    = 4;
  localparam int FUNC_W   = 4;
  localparam int ADDR_W   = 8;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t r;
    r.func = w[FUNC_LSB +: FUNC_W];
    r.rd   = w[RD_LSB   +: REG_W];
    r.rs1  = w[RS1_LSB  +: REG_W];
    r.rs2  = w[RS2_LSB  +: REG_W];
    r.addr = w[ADDR_LSB +: ADDR_W];
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-ROM fetch bus plus the issue bus towards the ALU pipeline front end.
interface alu_issue_ctrl_if #(
  parameter int IAW = 4
);
  logic [IAW-1:0] imem_addr;
  logic [23:0]    imem_data;
  logic [3:0]     rs1;
  logic [3:0]     rs2;
  logic [3:0]     rd;
  logic [3:0]     func;
  logic [7:0]     addr;
  logic           issue_valid;

  modport master (
    output imem_addr, rs1, rs2, rd, func, addr, issue_valid,
    input  imem_data
  );

  modport slave (
    input  imem_addr, rs1, rs2, rd, func, addr, issue_valid,
    output imem_data
  );
endinterface

// File: rtl/alu_scoreboard.sv
// RAW hazard scoreboard: WB_LAT-deep shift register of {valid,rd} for in-flight writes.
module alu_scoreboard #(
  parameter int WB_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [3:0] push_rd_i,
  input  logic [3:0] rs1_i,
  input  logic [3:0] rs2_i,
  output logic       hazard_o,
  output logic       empty_o
);

  logic [WB_LAT-1:0] vld_q;
  logic [3:0]        rd_q [WB_LAT];

  // Entries age by one slot every cycle; a new write enters at slot 0 as the oldest leaves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        rd_q[i] <= 4'd0;
      end
    end else begin
      vld_q   <= {vld_q[WB_LAT-2:0], push_i};
      rd_q[0] <= push_rd_i;
      for (int i = 1; i < WB_LAT; i++) begin
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  // Both source operands are always compared, whether or not the function reads them.
  always_comb begin
    hazard_o = 1'b0;
    empty_o  = 1'b1;
    for (int i = 0; i < WB_LAT; i++) begin
      if (vld_q[i]) begin
        empty_o = 1'b0;
        if ((rd_q[i] == rs1_i) || (rd_q[i] == rs2_i)) begin
          hazard_o = 1'b1;
        end else begin
          hazard_o = hazard_o;
        end
      end else begin
        empty_o = empty_o;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Fetch/decode/issue sequencer for the 4-stage ALU pipeline with RAW stall scoreboard.
// Optional feature: define ALU_PERF_CNT_EN to add issue/stall performance counters.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int IAW    = 4,
  parameter int WB_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [IAW:0]     prog_len_i,
  alu_issue_ctrl_if.master bus,
  output logic             busy_o,
`ifdef ALU_PERF_CNT_EN
  output logic [15:0]      issue_cnt_o,
  output logic [15:0]      stall_cnt_o,
`endif
  output logic             done_o
);

  state_e       state_q, state_d;
  logic [IAW:0] pc_q, pc_d;
  logic [IAW:0] len_q, len_d;
  logic [IAW:0] pc_inc_s;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  instr_t       out_q, out_d;
  instr_t       instr_s;
  logic         push_s;
  logic         stall_s;
  logic         clr_cnt_s;
  logic         hazard_s;
  logic         empty_s;

  assign instr_s  = decode(bus.imem_data);
  assign pc_inc_s = pc_q + {{IAW{1'b0}}, 1'b1};

  alu_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push_s),
    .push_rd_i (instr_s.rd),
    .rs1_i     (instr_s.rs1),
    .rs2_i     (instr_s.rs2),
    .hazard_o  (hazard_s),
    .empty_o   (empty_s)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    out_d     = out_q;
    push_s    = 1'b0;
    stall_s   = 1'b0;
    clr_cnt_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          clr_cnt_s = 1'b1;
          busy_d    = 1'b1;
          pc_d      = '0;
          len_d     = prog_len_i;
          if (prog_len_i != '0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (instr_s.func == FUNC_HALT) begin
          state_d = S_DRAIN;
        end else if (hazard_s) begin
          stall_s = 1'b1;
        end else begin
          push_s  = 1'b1;
          valid_d = 1'b1;
          out_d   = instr_s;
          pc_d    = pc_inc_s;
          // pc is one bit wider than the ROM address, so N = 2**IAW ends without wrapping.
          if (pc_inc_s == len_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        if (empty_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.imem_addr   = pc_q[IAW-1:0];
  assign bus.rs1         = out_q.rs1;
  assign bus.rs2         = out_q.rs2;
  assign bus.rd          = out_q.rd;
  assign bus.func        = out_q.func;
  assign bus.addr        = out_q.addr;
  assign bus.issue_valid = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

`ifdef ALU_PERF_CNT_EN
  logic [15:0] issue_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating counters, restarted on every accepted start.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_s) begin
      issue_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (push_s && (issue_cnt_q != 16'hFFFF)) begin
        issue_cnt_q <= issue_cnt_q + 16'h0001;
      end
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'h0001;
      end
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = ^{clr_cnt_s, stall_s};
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl: ROM model, expected-issue queue, done timing.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] prog_len;
  logic       busy;
  logic       done;
`ifdef ALU_PERF_CNT_EN
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;
`endif

  alu_issue_ctrl_if #(.IAW(4)) bus ();

  alu_issue_ctrl #(.IAW(4), .WB_LAT(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .prog_len_i (prog_len),
    .bus        (bus),
    .busy_o     (busy),
`ifdef ALU_PERF_CNT_EN
    .issue_cnt_o (issue_cnt),
    .stall_cnt_o (stall_cnt),
`endif
    .done_o     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] rom [16];
  int          errors = 0;
  int          checks = 0;
  time         t_start = 0;
  int          max_fetch = 0;
  logic        prev_valid = 1'b0;
  logic [23:0] last_word = 24'h0;

  // Instruction ROM: one-cycle registered read
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] rd,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [7:0] a);
    return {f, rd, r1, r2, a};
  endfunction

  task automatic push_exp(input logic [23:0] w, input int cyc);
    exp_t e;
    e.word = w;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 24'h0;
  endtask

  // Issue monitor: pop expected instruction, check word and cycle, then field hold
  always @(negedge clk) begin
    logic [23:0] cur;
    exp_t        e;
    cur = {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr};
    if (busy && (int'(bus.imem_addr) > max_fetch)) max_fetch = int'(bus.imem_addr);
    if (bus.issue_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {40'h0, cur}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("issue_word", {40'h0, cur}, {40'h0, e.word});
        check("issue_cycle", 64'(int'(($time - t_start - 5) / 10)), 64'(e.cyc));
      end
      last_word = cur;
    end else if (prev_valid && !rst) begin
      check("hold_fields", {40'h0, cur}, {40'h0, last_word});
    end
    prev_valid = bus.issue_valid;
  end

  task automatic run_prog(input int n, input int exp_done, input int extra_start);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    @(negedge clk);
    start    = 1'b1;
    prog_len = 5'(n);
    @(posedge clk);
    t_start = $time;
    #1;
    start     = 1'b0;
    max_fetch = 0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_after_start", {63'h0, busy}, 64'h1);
      if (k == extra_start) begin
        start    = 1'b1;
        prog_len = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", {63'h0, seen}, 64'h1);
    check("done_cycle", 64'(k), 64'(exp_done));
    @(negedge clk);
    check("busy_drop", {63'h0, busy}, 64'h0);
    check("done_pulse_len", {63'h0, done}, 64'h0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
  endtask

  task automatic load_indep3();
    clear_rom();
    rom[0] = mk(4'h0, 4'd10, 4'd1, 4'd2, 8'h10);
    rom[1] = mk(4'h1, 4'd11, 4'd3, 4'd4, 8'h11);
    rom[2] = mk(4'h2, 4'd12, 4'd5, 4'd1, 8'h12);
    push_exp(rom[0], 2);
    push_exp(rom[1], 4);
    push_exp(rom[2], 6);
  endtask

  initial begin
    bit any_done;
    clear_rom();
    rst      = 1'b1;
    start    = 1'b1;
    prog_len = 5'd3;

    // Reset held two cycles with start asserted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_valid", {63'h0, bus.issue_valid}, 64'h0);
    check("rst_imem_addr", {60'h0, bus.imem_addr}, 64'h0);
    check("rst_fields", {40'h0, bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr}, 64'h0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("start_in_reset_ignored", {63'h0, busy}, 64'h0);

    // Three independent instructions, stray start mid-program
    load_indep3();
    run_prog(3, 10, 3);

    // RAW hazard: i1 reads r10 written by i0
    clear_rom();
    rom[0] = mk(4'h0, 4'd10, 4'd1, 4'd2, 8'h20);
    rom[1] = mk(4'h3, 4'd13, 4'd10, 4'd4, 8'h21);
    push_exp(rom[0], 2);
    push_exp(rom[1], 6);
    run_prog(2, 10, -1);
`ifdef ALU_PERF_CNT_EN
    check("raw_stall_cnt", {48'h0, stall_cnt}, 64'd2);
    check("raw_issue_cnt", {48'h0, issue_cnt}, 64'd2);
`endif

    // HALT at word 1: words 2 and 3 never fetched
    clear_rom();
    rom[0] = mk(4'h4, 4'd9, 4'd1, 4'd2, 8'h30);
    rom[1] = mk(4'hF, 4'd8, 4'd0, 4'd0, 8'h31);
    rom[2] = mk(4'h5, 4'd7, 4'd1, 4'd1, 8'h32);
    rom[3] = mk(4'h6, 4'd6, 4'd1, 4'd1, 8'h33);
    push_exp(rom[0], 2);
    run_prog(4, 6, -1);
    check("halt_max_fetch", 64'(max_fetch), 64'd1);
`ifdef ALU_PERF_CNT_EN
    check("halt_issue_cnt", {48'h0, issue_cnt}, 64'd1);
    check("halt_stall_cnt", {48'h0, stall_cnt}, 64'd0);
`endif

    // Empty program
    run_prog(0, 0, -1);
`ifdef ALU_PERF_CNT_EN
    check("n0_issue_cnt", {48'h0, issue_cnt}, 64'd0);
`endif

    // Full 16-entry program, no pc wrap
    for (int i = 0; i < 16; i++) begin
      rom[i] = mk(4'(i % 12), 4'(8 + i % 8), 4'(i % 8), 4'((i + 3) % 8), 8'(i));
      push_exp(rom[i], 2 + 2 * i);
    end
    run_prog(16, 36, -1);
    check("full_max_fetch", 64'(max_fetch), 64'd15);

    // Reset while stalled in ISSUE with pending scoreboard entry
    clear_rom();
    rom[0] = mk(4'h0, 4'd10, 4'd1, 4'd2, 8'h40);
    rom[1] = mk(4'h3, 4'd13, 4'd10, 4'd4, 8'h41);
    push_exp(rom[0], 2);
    @(negedge clk);
    start    = 1'b1;
    prog_len = 5'd2;
    @(posedge clk);
    t_start = $time;
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_valid", {63'h0, bus.issue_valid}, 64'h0);
    check("midrst_imem_addr", {60'h0, bus.imem_addr}, 64'h0);
    rst      = 1'b0;
    any_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check("midrst_no_done", {63'h0, any_done}, 64'h0);
    check("midrst_queue", 64'(exp_q.size()), 64'h0);

    // Clean restart after abort
    load_indep3();
    run_prog(3, 10, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
